// File: rtl/ddr_pll_seq_pkg.sv
// ddr_pll_seq_pkg: state encoding and counter-width helper for the DDR PLL sequencer.
package ddr_pll_seq_pkg;
   typedef enum logic [2:0] {
      RESET_PLS = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      EN_CLK    = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } state_t;

   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/ddr_pll_seq_lock_sync.sv
// pll_lock_sync: 2-FF synchroniser for the asynchronous PLL LOCK input.
module pll_lock_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic s1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, s1} <= 2'b00;
      else        {q, s1} <= {s1, d};
endmodule

// File: rtl/ddr_pll_seq.sv
// ddr_pll_seq: DDR PLL power-up/relock sequencer (reset pulse, lock qualify, staggered ENCLK, DDR reset).
// Optional DDR_PLL_SEQ_STATS_EN adds a saturating relock_cnt output.
module ddr_pll_seq
   import ddr_pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int ENCLK_GAP_CYC    = 8,
   parameter int MAX_RETRY        = 3,
   parameter int N_CLK            = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restart,
   input  logic             pll_lock,
   output logic             pll_reset,
   output logic [N_CLK-1:0] pll_enclk,
   output logic             ready,
   output logic             ddr_rst_n,
   output logic             fail,
   output logic [2:0]       state_o
`ifdef DDR_PLL_SEQ_STATS_EN
   ,
   output logic [7:0]       relock_cnt
`endif
);
   localparam int M1   = RST_PULSE_CYC > LOCK_STABLE_CYC ? RST_PULSE_CYC : LOCK_STABLE_CYC;
   localparam int M2   = LOCK_TIMEOUT_CYC > ENCLK_GAP_CYC ? LOCK_TIMEOUT_CYC : ENCLK_GAP_CYC;
   localparam int CMAX = M1 > M2 ? M1 : M2;
   localparam int CW   = cnt_w(CMAX);
   localparam int RW   = cnt_w(MAX_RETRY);
   localparam logic [CW-1:0] RST_L  = CW'(RST_PULSE_CYC);
   localparam logic [CW-1:0] STB_L  = CW'(LOCK_STABLE_CYC);
   localparam logic [CW-1:0] TO_L   = CW'(LOCK_TIMEOUT_CYC);
   localparam logic [CW-1:0] GAP_L  = CW'(ENCLK_GAP_CYC);
   localparam logic [CW-1:0] CMAX_L = CW'(CMAX);
   localparam logic [RW-1:0] MAXR_L = RW'(MAX_RETRY);

   state_t           state, state_d;
   logic [CW-1:0]    cnt, cnt_d, cnt_inc;
   logic [RW-1:0]    retry, retry_d, retry_inc;
   logic             lock_s, pll_reset_d, ready_d, fail_d;
   logic [N_CLK-1:0] enclk_d;

   pll_lock_sync u_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock), .q(lock_s));

   assign cnt_inc   = cnt == CMAX_L ? cnt : cnt + CW'(1);
   assign retry_inc = retry == MAXR_L ? retry : retry + RW'(1);
   assign state_o   = state;

   always_comb begin
      state_d     = state;
      cnt_d       = cnt_inc;
      retry_d     = retry;
      pll_reset_d = pll_reset;
      enclk_d     = pll_enclk;
      ready_d     = ready;
      fail_d      = fail;
      if (restart) begin
         state_d     = RESET_PLS;
         cnt_d       = '0;
         retry_d     = '0;
         pll_reset_d = 1'b1;
         enclk_d     = '0;
         ready_d     = 1'b0;
         fail_d      = 1'b0;
      end else begin
         case (state)
            RESET_PLS:
               if (cnt_inc == RST_L) begin
                  state_d     = WAIT_LOCK;
                  cnt_d       = '0;
                  pll_reset_d = 1'b0;
               end
            WAIT_LOCK:
               if (lock_s) begin
                  state_d = STABLE;
                  cnt_d   = '0;
               end else if (cnt_inc == TO_L) begin
                  cnt_d       = '0;
                  retry_d     = retry_inc;
                  pll_reset_d = 1'b1;
                  fail_d      = retry_inc == MAXR_L;
                  state_d     = retry_inc == MAXR_L ? FAIL : RESET_PLS;
               end
            STABLE:
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_inc == STB_L) begin
                  state_d = EN_CLK;
                  cnt_d   = '0;
                  enclk_d = N_CLK'(1);
               end
            EN_CLK, RUN:
               // lock loss is a relock, not a timeout: retries start over
               if (!lock_s) begin
                  state_d     = RESET_PLS;
                  cnt_d       = '0;
                  retry_d     = '0;
                  pll_reset_d = 1'b1;
                  enclk_d     = '0;
                  ready_d     = 1'b0;
               end else if (state == EN_CLK && cnt_inc == GAP_L) begin
                  cnt_d   = '0;
                  state_d = &pll_enclk ? RUN : EN_CLK;
                  ready_d = &pll_enclk;
                  enclk_d = (pll_enclk << 1) | N_CLK'(1);
               end
            FAIL: ;
            default: state_d = RESET_PLS;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= RESET_PLS;
         cnt       <= '0;
         retry     <= '0;
         pll_reset <= 1'b1;
         pll_enclk <= '0;
         ready     <= 1'b0;
         ddr_rst_n <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         retry     <= retry_d;
         pll_reset <= pll_reset_d;
         pll_enclk <= enclk_d;
         ready     <= ready_d;
         ddr_rst_n <= ready & ready_d;
         fail      <= fail_d;
      end

`ifdef DDR_PLL_SEQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         relock_cnt <= '0;
      else if (!restart && !lock_s && (state == EN_CLK || state == RUN) && relock_cnt != 8'hff)
         relock_cnt <= relock_cnt + 8'd1;
`endif
endmodule
